exe_stage: RTL and testbench

- Execute stage of the 5-stage in-order LoongArch32 pipeline; sits between the decode stage and the memory stage.
- Latches the decode-to-execute bus and computes the ALU, multiply and iterative divide results.
- Issues the data-SRAM request for loads and stores.
- Returns forwarding and hazard information (exe_rf_we, exe_dest, alu_result, es_block) to decode.

---
 rtl/exe_stage_pkg.sv | 59 +++++
 rtl/exe_stage_if.sv | 40 ++++
 rtl/exe_divider.sv | 96 +++++++++
 rtl/exe_stage.sv | 123 ++++++++++++
 tb/tb_exe_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, alu_op bit indices,
// store_op bit indices, divider state encoding and bus layouts.
package exe_stage_pkg;

    localparam int DS2ES_BUS_LEN = 162;
    localparam int ES2MS_BUS_LEN = 77;
    localparam int DIV_CYCLES    = 32;

    // alu_op one-hot bit positions
    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_NOR   = 5;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_SLL   = 8;
    localparam int OP_SRL   = 9;
    localparam int OP_SRA   = 10;
    localparam int OP_LUI   = 11;
    localparam int OP_MUL   = 12;
    localparam int OP_MULH  = 13;
    localparam int OP_MULHU = 14;
    localparam int OP_DIV   = 15;
    localparam int OP_MOD   = 16;
    localparam int OP_DIVU  = 17;
    localparam int OP_MODU  = 18;

    // store_op one-hot bit positions
    localparam int ST_B = 0;
    localparam int ST_H = 1;
    localparam int ST_W = 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [18:0] alu_op;
        logic [4:0]  load_op;
        logic [2:0]  store_op;
        logic [31:0] rkd_value;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_we;
    } ds2es_t;

    // Magnitude of v when treated as signed, v itself otherwise.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode/execute/memory handshake, forwarding and data-SRAM signals.
// Handshake: a transfer happens on a rising clk edge when the producer's
// valid and the consumer's allowin are both high; the producer holds its
// bus stable while valid is high and allowin is low.
// slave = execute stage, master = surrounding pipeline.
// div_state is a debug view of the divider FSM.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                     ds2es_valid;
    logic                     es_allowin;
    logic [DS2ES_BUS_LEN-1:0] ds2es_bus;
    logic                     ms_allowin;
    logic                     es2ms_valid;
    logic [ES2MS_BUS_LEN-1:0] es2ms_bus;
    logic                     exe_rf_we;
    logic [4:0]               exe_dest;
    logic [31:0]              alu_result;
    logic                     es_block;
    logic                     data_sram_en;
    logic [3:0]               data_sram_we;
    logic [31:0]              data_sram_addr;
    logic [31:0]              data_sram_wdata;
    div_state_t               div_state;

    modport slave (
        input  ds2es_valid, ds2es_bus, ms_allowin,
        output es_allowin, es2ms_valid, es2ms_bus, exe_rf_we, exe_dest,
               alu_result, es_block, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, div_state
    );

    modport master (
        output ds2es_valid, ds2es_bus, ms_allowin,
        input  es_allowin, es2ms_valid, es2ms_bus, exe_rf_we, exe_dest,
               alu_result, es_block, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, div_state
    );

endinterface

// File: rtl/exe_divider.sv
// Iterative restoring divider, one quotient bit per cycle on magnitudes,
// sign fixups applied on the outputs.
// Optional macro EXE_DIV_ZERO_FAST_EN: a zero divisor finishes after one
// BUSY cycle with the same values the full iteration would produce.
module exe_divider
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output div_state_t  state
);

    div_state_t  state_nxt;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [5:0]  cnt_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic [32:0] shifted;
    logic        ge;
    logic        last_step;
`ifdef EXE_DIV_ZERO_FAST_EN
    logic        zero_r;
`endif

    // Trial subtraction for the current step and end-of-iteration detect
    always_comb begin
        shifted   = {rem_r, quo_r[31]};
        ge        = (shifted >= {1'b0, dvs_r});
        last_step = (cnt_r == 6'(DIV_CYCLES - 1));
`ifdef EXE_DIV_ZERO_FAST_EN
        if (zero_r) last_step = 1'b1;
`endif
    end

    // FSM state register; reset abandons any division in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start)     state_nxt = DIV_BUSY;
            DIV_BUSY: if (last_step) state_nxt = DIV_DONE;
            DIV_DONE: if (ack)       state_nxt = DIV_IDLE;
            default:                 state_nxt = DIV_IDLE;
        endcase
    end

    // FSM outputs: done flag and sign-corrected results
    always_comb begin
        done      = (state == DIV_DONE);
        quotient  = q_neg_r ? (~quo_r + 32'd1) : quo_r;
        remainder = r_neg_r ? (~rem_r + 32'd1) : rem_r;
    end

    // Operand capture on start, one restoring step per BUSY cycle
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start) begin
            quo_r   <= abs32(dividend, is_signed);
            rem_r   <= '0;
            dvs_r   <= abs32(divisor, is_signed);
            cnt_r   <= '0;
            q_neg_r <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg_r <= is_signed & dividend[31];
`ifdef EXE_DIV_ZERO_FAST_EN
            zero_r  <= (divisor == 32'd0);
`endif
        end else if (state == DIV_BUSY) begin
`ifdef EXE_DIV_ZERO_FAST_EN
            if (zero_r) begin
                rem_r <= quo_r;
                quo_r <= '1;
            end else
`endif
            begin
                rem_r <= ge ? 32'(shifted - {1'b0, dvs_r}) : shifted[31:0];
                quo_r <= {quo_r[30:0], ge};
                cnt_r <= cnt_r + 6'd1;
            end
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU / multiply / divide
// results, issues the data-SRAM request and reports forwarding info.
// Optional macro EXE_DIV_ZERO_FAST_EN (inside exe_divider) shortens
// divide-by-zero.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    exe_stage_if.slave io
);

    logic        es_valid;
    logic        es_ready_go;
    logic        es_allowin;
    ds2es_t      es_r;
    logic        div_op;
    logic        mul_op;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] sum;
    logic [31:0] alu_res;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] result;
    logic [3:0]  strobe;
    logic [31:0] wdata;

    assign div_op      = |es_r.alu_op[OP_MODU:OP_DIV];
    assign mul_op      = |es_r.alu_op[OP_MULHU:OP_MUL];
    assign es_ready_go = ~div_op | div_done;
    assign es_allowin  = ~es_valid | (es_ready_go & io.ms_allowin);

    // Valid bit: refilled from decode whenever the stage may accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           es_valid <= 1'b0;
        else if (es_allowin) es_valid <= io.ds2es_valid;
    end

    // Bus register: captured only on an accepted transfer
    always_ff @(posedge clk) begin
        if (io.ds2es_valid && es_allowin) es_r <= io.ds2es_bus;
    end

    exe_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid & div_op),
        .is_signed (es_r.alu_op[OP_DIV] | es_r.alu_op[OP_MOD]),
        .dividend  (es_r.src1),
        .divisor   (es_r.src2),
        .ack       (io.es2ms_valid & io.ms_allowin),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r),
        .state     (io.div_state)
    );

    assign sum   = es_r.src1 + es_r.src2;
    assign mul_a = {{32{(es_r.alu_op[OP_MUL] | es_r.alu_op[OP_MULH]) & es_r.src1[31]}}, es_r.src1};
    assign mul_b = {{32{(es_r.alu_op[OP_MUL] | es_r.alu_op[OP_MULH]) & es_r.src2[31]}}, es_r.src2};
    assign prod  = mul_a * mul_b;

    // One-hot ALU operation select
    always_comb begin
        alu_res = '0;
        case (1'b1)
            es_r.alu_op[OP_ADD]:  alu_res = sum;
            es_r.alu_op[OP_SUB]:  alu_res = es_r.src1 - es_r.src2;
            es_r.alu_op[OP_SLT]:  alu_res = {31'd0, $signed(es_r.src1) < $signed(es_r.src2)};
            es_r.alu_op[OP_SLTU]: alu_res = {31'd0, es_r.src1 < es_r.src2};
            es_r.alu_op[OP_AND]:  alu_res = es_r.src1 & es_r.src2;
            es_r.alu_op[OP_NOR]:  alu_res = ~(es_r.src1 | es_r.src2);
            es_r.alu_op[OP_OR]:   alu_res = es_r.src1 | es_r.src2;
            es_r.alu_op[OP_XOR]:  alu_res = es_r.src1 ^ es_r.src2;
            es_r.alu_op[OP_SLL]:  alu_res = es_r.src1 << es_r.src2[4:0];
            es_r.alu_op[OP_SRL]:  alu_res = es_r.src1 >> es_r.src2[4:0];
            es_r.alu_op[OP_SRA]:  alu_res = $unsigned($signed(es_r.src1) >>> es_r.src2[4:0]);
            es_r.alu_op[OP_LUI]:  alu_res = es_r.src2;
            default:              alu_res = '0;
        endcase
    end

    // Final result: divider, then multiplier, then ALU
    always_comb begin
        if (es_r.alu_op[OP_DIV] | es_r.alu_op[OP_DIVU])      result = div_q;
        else if (es_r.alu_op[OP_MOD] | es_r.alu_op[OP_MODU]) result = div_r;
        else if (es_r.alu_op[OP_MUL])                        result = prod[31:0];
        else if (mul_op)                                     result = prod[63:32];
        else                                                 result = alu_res;
    end

    // Store byte strobes and lane-replicated write data
    always_comb begin
        strobe = 4'b0000;
        wdata  = es_r.rkd_value;
        if (es_r.store_op[ST_B]) begin
            strobe = 4'b0001 << sum[1:0];
            wdata  = {4{es_r.rkd_value[7:0]}};
        end else if (es_r.store_op[ST_H]) begin
            strobe = 4'b0011 << {sum[1], 1'b0};
            wdata  = {2{es_r.rkd_value[15:0]}};
        end else if (es_r.store_op[ST_W]) begin
            strobe = 4'b1111;
        end
    end

    assign io.es_allowin      = es_allowin;
    assign io.es2ms_valid     = es_valid & es_ready_go;
    assign io.es2ms_bus       = es_valid ? {es_r.pc, result, es_r.load_op, es_r.gr_we,
                                            es_r.dest, sum[1:0]} : '0;
    assign io.exe_rf_we       = es_valid & es_r.gr_we;
    assign io.exe_dest        = es_valid ? es_r.dest : 5'd0;
    assign io.alu_result      = es_valid ? result : 32'd0;
    assign io.es_block        = es_valid & (|es_r.load_op | mul_op | (div_op & ~div_done));
    assign io.data_sram_en    = es_valid & (|es_r.load_op | es_r.mem_we) & io.ms_allowin;
    assign io.data_sram_we    = (es_valid & es_r.mem_we) ? strobe : 4'b0000;
    assign io.data_sram_addr  = es_valid ? sum : 32'd0;
    assign io.data_sram_wdata = es_valid ? wdata : 32'd0;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed scenarios plus randomized traffic,
// scoreboard queues checked by an independent monitor.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    exe_stage_if io ();

    exe_stage dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [76:0] exp_q[$];
    logic [67:0] exp_mem_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [18:0] opb(input int i);
        logic [18:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [161:0] mk(input logic [31:0] pc, input logic [31:0] a,
                                         input logic [31:0] b, input logic [18:0] alu,
                                         input logic [4:0] ld, input logic [2:0] st,
                                         input logic [31:0] rkd, input logic we,
                                         input logic [4:0] dest, input logic mw);
        return {pc, a, b, alu, ld, st, rkd, we, dest, mw};
    endfunction

    // Reference arithmetic using wide integer math
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (ua < ub) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  begin p = ua << b[4:0]; return p[31:0]; end
            9:  return a >> b[4:0];
            10: begin p = sa >>> b[4:0]; return p[31:0]; end
            11: return b;
            12: begin p = sa * sb; return p[31:0]; end
            13: begin p = sa * sb; return p[63:32]; end
            14: begin p = ua * ub; return p[63:32]; end
            15: begin
                if (b == 0) return a[31] ? 32'h1 : 32'hffffffff;
                p = sa / sb; return p[31:0];
            end
            16: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            17: return (b == 0) ? 32'hffffffff : a / b;
            18: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Push the expected memory-stage bus and SRAM request for an accepted instruction
    task automatic expect_instr(input logic [161:0] bus);
        logic [31:0] pc, a, b, rkd, addr, res, wd;
        logic [18:0] alu;
        logic [4:0]  ld, dest;
        logic [2:0]  st;
        logic        we, mw;
        logic [3:0]  s;
        int          op;
        {pc, a, b, alu, ld, st, rkd, we, dest, mw} = bus;
        op = 0;
        for (int i = 0; i < 19; i++) if (alu[i]) op = i;
        res  = ref_result(op, a, b);
        addr = a + b;
        exp_q.push_back({pc, res, ld, we, dest, addr[1:0]});
        if (|ld || mw) begin
            s  = 4'b0000;
            wd = rkd;
            if (mw && st[0]) begin
                s[addr[1:0]] = 1'b1;
                wd = {4{rkd[7:0]}};
            end else if (mw && st[1]) begin
                s[{addr[1], 1'b0} +: 2] = 2'b11;
                wd = {2{rkd[15:0]}};
            end else if (mw && st[2]) begin
                s = 4'b1111;
            end
            exp_mem_q.push_back({s, addr, wd});
        end
    endtask

    task automatic wait_cycle();
        @(negedge clk);
        #2;
    endtask

    // Offer one instruction, hold it until accepted, then drop valid
    task automatic send(input logic [161:0] b);
        int n;
        n = 0;
        io.ds2es_bus   = b;
        io.ds2es_valid = 1'b1;
        #1;
        while (!io.es_allowin && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (!io.es_allowin) begin
            check("send_timeout", 1'b0, 1'b1);
        end else begin
            expect_instr(b);
        end
        wait_cycle();
        io.ds2es_valid = 1'b0;
    endtask

    // Divide scenario: latency, stall behaviour and final forwarded value
    task automatic div_test(input string name, input int op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int k;
        bit stall_ok;
        wait_cycle();
        send(mk(32'h1c000100, a, b, opb(op), 5'd0, 3'd0, 32'd0, 1'b1, 5'd9, 1'b0));
        k = 0;
        stall_ok = 1'b1;
        #1;
        while (!io.es2ms_valid && k < 100) begin
            if (!(io.es_block && !io.es_allowin)) stall_ok = 1'b0;
            wait_cycle();
            #1;
            k++;
        end
        check({name, "_latency"}, k, exp_lat);
        check({name, "_stall"}, stall_ok, 1'b1);
        check({name, "_result"}, io.alu_result, exp_res);
        check({name, "_unblocked"}, io.es_block, 1'b0);
    endtask

    function automatic logic [161:0] rand_instr();
        int          kind;
        logic [31:0] a, b, rkd, pc;
        logic [4:0]  dest, l;
        logic [2:0]  s;
        logic        we;
        logic [31:0] edges[5];
        edges = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
        kind = $urandom_range(0, 9);
        a    = $urandom;
        b    = $urandom;
        rkd  = $urandom;
        pc   = $urandom & 32'hfffffffc;
        dest = 5'($urandom_range(0, 31));
        we   = 1'($urandom_range(0, 1));
        if (kind <= 5) begin
            return mk(pc, a, b, opb($urandom_range(0, 14)), 5'd0, 3'd0, rkd, we, dest, 1'b0);
        end else if (kind == 6) begin
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) b = -b;
            return mk(pc, a, b, opb($urandom_range(15, 18)), 5'd0, 3'd0, rkd, we, dest, 1'b0);
        end else if (kind == 7) begin
            l = '0;
            l[$urandom_range(0, 4)] = 1'b1;
            return mk(pc, a, 32'($urandom_range(0, 4095)), opb(OP_ADD), l, 3'd0, rkd, 1'b1, dest, 1'b0);
        end else if (kind == 8) begin
            s = '0;
            s[$urandom_range(0, 2)] = 1'b1;
            return mk(pc, a, 32'($urandom_range(0, 4095)), opb(OP_ADD), 5'd0, s, rkd, 1'b0, 5'd0, 1'b1);
        end
        return mk(pc, edges[$urandom_range(0, 4)], edges[$urandom_range(0, 4)],
                  opb($urandom_range(0, 18)), 5'd0, 3'd0, rkd, we, dest, 1'b0);
    endfunction

    // Monitor: compare every transfer and every SRAM request against the queues
    initial begin
        logic [76:0] e;
        logic [67:0] m;
        wait (reset === 1'b0);
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                if (io.es2ms_valid && io.ms_allowin) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL es2ms_unexpected: got %0h expected no transfer", io.es2ms_bus);
                    end else begin
                        e = exp_q.pop_front();
                        check("es2ms_bus", io.es2ms_bus, e);
                    end
                end
                if (io.data_sram_en) begin
                    if (exp_mem_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL sram_unexpected: got addr %0h expected no request", io.data_sram_addr);
                    end else begin
                        m = exp_mem_q.pop_front();
                        check("sram_req", {io.data_sram_we, io.data_sram_addr, io.data_sram_wdata}, m);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    localparam int ZERO_LAT =
`ifdef EXE_DIV_ZERO_FAST_EN
        2;
`else
        33;
`endif

    initial begin
        logic [161:0] cur;
        bit           pending;
        bit           ok;
        int           n;

        reset          = 1'b1;
        io.ds2es_valid = 1'b0;
        io.ds2es_bus   = '0;
        io.ms_allowin  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_allowin", io.es_allowin, 1'b1);
        check("rst_es2ms_valid", io.es2ms_valid, 1'b0);
        check("rst_rf_we", io.exe_rf_we, 1'b0);
        check("rst_alu_result", io.alu_result, 32'd0);
        check("rst_sram_en", io.data_sram_en, 1'b0);
        check("rst_block", io.es_block, 1'b0);
        check("rst_div_state", io.div_state, DIV_IDLE);

        // add.w 5 + 7
        wait_cycle();
        send(mk(32'h1c000000, 32'd5, 32'd7, opb(OP_ADD), 5'd0, 3'd0, 32'd0, 1'b1, 5'd3, 1'b0));
        #1;
        check("add_valid", io.es2ms_valid, 1'b1);
        check("add_result", io.alu_result, 32'd12);
        check("add_block", io.es_block, 1'b0);
        check("add_rf_we", io.exe_rf_we, 1'b1);
        check("add_dest", io.exe_dest, 5'd3);

        div_test("div_w", OP_DIV, 32'hfffffff9, 32'd2, 33, 32'hfffffffd);
        div_test("mod_w", OP_MOD, 32'hfffffff9, 32'd2, 33, 32'hffffffff);
        div_test("divu_zero", OP_DIVU, 32'h1234, 32'd0, ZERO_LAT, 32'hffffffff);
        div_test("modu_zero", OP_MODU, 32'h1234, 32'd0, ZERO_LAT, 32'h1234);
        div_test("div_w_zero", OP_DIV, 32'hfffffffb, 32'd0, ZERO_LAT, 32'h1);
        div_test("div_w_ovf", OP_DIV, 32'h80000000, 32'hffffffff, 33, 32'h80000000);

        // st.b 0xAB at 0x1003
        wait_cycle();
        send(mk(32'h1c000200, 32'h1000, 32'h3, opb(OP_ADD), 5'd0, 3'b001, 32'hAB, 1'b0, 5'd0, 1'b1));
        #1;
        check("stb_en", io.data_sram_en, 1'b1);
        check("stb_we", io.data_sram_we, 4'b1000);
        check("stb_wdata", io.data_sram_wdata, 32'hABABABAB);
        check("stb_addr", io.data_sram_addr, 32'h1003);
        wait_cycle();
        #1;
        check("stb_en_pulse", io.data_sram_en, 1'b0);

        // ld.w stalled by the memory stage for 3 cycles
        wait_cycle();
        io.ms_allowin = 1'b0;
        send(mk(32'h1c000300, 32'h2000, 32'h8, opb(OP_ADD), 5'b00100, 3'd0, 32'd0, 1'b1, 5'd7, 1'b0));
        ok = 1'b1;
        repeat (3) begin
            #1;
            if (io.data_sram_en || !io.es_block) ok = 1'b0;
            wait_cycle();
        end
        check("ld_stall", ok, 1'b1);
        io.ms_allowin = 1'b1;
        #1;
        check("ld_en", io.data_sram_en, 1'b1);
        check("ld_block", io.es_block, 1'b1);
        wait_cycle();
        #1;
        check("ld_en_pulse", io.data_sram_en, 1'b0);

        // Reset while the divider is busy
        wait_cycle();
        send(mk(32'h1c000400, 32'd100, 32'd7, opb(OP_DIV), 5'd0, 3'd0, 32'd0, 1'b1, 5'd4, 1'b0));
        repeat (10) wait_cycle();
        #1;
        check("rst_mid_busy", io.div_state, DIV_BUSY);
        reset = 1'b1;
        #1;
        check("rst_mid_state", io.div_state, DIV_IDLE);
        check("rst_mid_valid", io.es2ms_valid, 1'b0);
        check("rst_mid_allowin", io.es_allowin, 1'b1);
        exp_q.delete();
        exp_mem_q.delete();
        wait_cycle();
        reset = 1'b0;
        div_test("div_after_rst", OP_DIV, 32'd100, 32'd7, 33, 32'd14);

        // Randomized traffic with random back-pressure
        pending = 1'b0;
        cur     = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            wait_cycle();
            io.ms_allowin = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 2) != 0) begin
                cur     = rand_instr();
                pending = 1'b1;
            end
            io.ds2es_valid = pending;
            io.ds2es_bus   = cur;
            #1;
            if (pending && io.es_allowin) begin
                expect_instr(cur);
                pending = 1'b0;
            end
        end
        wait_cycle();
        io.ds2es_valid = 1'b0;
        io.ms_allowin  = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && n < 200) begin
            wait_cycle();
            n++;
        end
        check("drain_bus", exp_q.size(), 0);
        check("drain_mem", exp_mem_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
